// File: rtl/memory_game_pkg.sv
// Shared types and constants for the memory game round sequencer.
package memory_game_pkg;

  localparam int TARGET_W = 4;

  // Encodings are shown on the debug LEDs, so they are fixed explicitly.
  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_WAIT_RND   = 3'd1,
    ST_SHOW       = 3'd2,
    ST_WAIT_GUESS = 3'd3,
    ST_CHECK      = 3'd4,
    ST_RESULT     = 3'd5,
    ST_OVER       = 3'd6
  } state_e;

endpackage

// File: rtl/game_timer.sv
// Shared phase timer: 32-bit down-counter with a registered one-cycle expire
// pulse, raised in the last cycle of a window of value_i cycles after a load.
module game_timer (
  input  logic        clk,
  input  logic        rst,
  input  logic        load_i,
  input  logic [31:0] value_i,
  output logic        expire_o
);

  logic [31:0] count_q;
  logic        expire_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count_q  <= '0;
      expire_q <= 1'b0;
    end else if (load_i) begin
      count_q  <= value_i;
      expire_q <= (value_i == 32'd1);
    end else begin
      // count_q reads 1 in the final cycle of the window, so flag it one early
      expire_q <= (count_q == 32'd2);
      if (count_q != 32'd0) count_q <= count_q - 32'd1;
    end
  end

  assign expire_o = expire_q;

endmodule

// File: rtl/memory_game_sequencer.sv
// Round sequencer: shows a captured random target, times the player's guess,
// scores the round and tracks lives until game over.
module memory_game_sequencer
  import memory_game_pkg::*;
#(
  parameter logic [31:0] SHOW_CYCLES   = 32'd100_000_000,
  parameter logic [31:0] GUESS_CYCLES  = 32'd250_000_000,
  parameter logic [31:0] RESULT_CYCLES = 32'd50_000_000,
  parameter int          LIVES         = 3,
  parameter int          SCORE_W       = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic                rnd_valid,
  input  logic [TARGET_W-1:0] rnd_val,
  input  logic                guess_valid,
  input  logic [TARGET_W-1:0] guess_val,
  output logic                disp_on,
  output logic [TARGET_W-1:0] disp_val,
  output logic                correct,
  output logic                wrong,
  output logic                verdict,
  output logic [SCORE_W-1:0]  score,
  output logic [1:0]          lives,
  output logic                game_over,
  output logic [2:0]          state_code
);

  localparam logic [1:0] LIVES_INIT = 2'(LIVES);

  state_e              state_q, state_d;
  logic [TARGET_W-1:0] target_q, target_d;
  logic [TARGET_W-1:0] guess_q, guess_d;
  logic                timeout_q, timeout_d;
  logic [SCORE_W-1:0]  score_q, score_d;
  logic [1:0]          lives_q, lives_d;
  logic                correct_q, correct_d;
  logic                wrong_q, wrong_d;
  logic                verdict_q, verdict_d;
  logic                tmr_load;
  logic [31:0]         tmr_value;
  logic                tmr_expire;

  game_timer u_timer (
    .clk      (clk),
    .rst      (rst),
    .load_i   (tmr_load),
    .value_i  (tmr_value),
    .expire_o (tmr_expire)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= ST_IDLE;
      target_q  <= '0;
      guess_q   <= '0;
      timeout_q <= 1'b0;
      score_q   <= '0;
      lives_q   <= '0;
      correct_q <= 1'b0;
      wrong_q   <= 1'b0;
      verdict_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      target_q  <= target_d;
      guess_q   <= guess_d;
      timeout_q <= timeout_d;
      score_q   <= score_d;
      lives_q   <= lives_d;
      correct_q <= correct_d;
      wrong_q   <= wrong_d;
      verdict_q <= verdict_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    target_d  = target_q;
    guess_d   = guess_q;
    timeout_d = timeout_q;
    score_d   = score_q;
    lives_d   = lives_q;
    correct_d = 1'b0;
    wrong_d   = 1'b0;
    verdict_d = verdict_q;
    tmr_load  = 1'b0;
    tmr_value = '0;
    unique case (state_q)
      ST_IDLE, ST_OVER: begin
        if (start) begin
          score_d = '0;
          lives_d = LIVES_INIT;
          state_d = ST_WAIT_RND;
        end
      end
      ST_WAIT_RND: begin
        if (rnd_valid) begin
          target_d  = rnd_val;
          tmr_load  = 1'b1;
          tmr_value = SHOW_CYCLES;
          state_d   = ST_SHOW;
        end
      end
      ST_SHOW: begin
        if (tmr_expire) begin
          tmr_load  = 1'b1;
          tmr_value = GUESS_CYCLES;
          state_d   = ST_WAIT_GUESS;
        end
      end
      ST_WAIT_GUESS: begin
        // a guess landing on the expiry cycle still counts as a guess
        if (guess_valid) begin
          guess_d   = guess_val;
          timeout_d = 1'b0;
          state_d   = ST_CHECK;
        end else if (tmr_expire) begin
          timeout_d = 1'b1;
          state_d   = ST_CHECK;
        end
      end
      ST_CHECK: begin
        tmr_load  = 1'b1;
        tmr_value = RESULT_CYCLES;
        state_d   = ST_RESULT;
        if (!timeout_q && (guess_q == target_q)) begin
          correct_d = 1'b1;
          verdict_d = 1'b1;
          if (score_q != '1) score_d = score_q + 1'b1;
        end else begin
          wrong_d   = 1'b1;
          verdict_d = 1'b0;
          if (lives_q != 2'd0) lives_d = lives_q - 2'd1;
        end
      end
      ST_RESULT: begin
        if (tmr_expire) begin
          verdict_d = 1'b0;
          state_d   = (lives_q == 2'd0) ? ST_OVER : ST_WAIT_RND;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign disp_on    = (state_q == ST_SHOW);
  assign disp_val   = disp_on ? target_q : '0;
  assign correct    = correct_q;
  assign wrong      = wrong_q;
  assign verdict    = verdict_q;
  assign score      = score_q;
  assign lives      = lives_q;
  assign game_over  = (state_q == ST_OVER);
  assign state_code = state_q;

endmodule
